// File: rtl/exe_commit_arbiter_pkg.sv
// exe_commit_arbiter_pkg: shared execute-to-commit types and sizing
package exe_commit_arbiter_pkg;
  localparam int NUM_EXE_UNITS = 4;
  localparam int NUM_COMMIT_PORTS = 2;
  typedef enum logic [1:0] {UNIT_ALU1, UNIT_ALU2, UNIT_MDU, UNIT_LSU} unit_idx_e;
  typedef struct packed {
    logic [5:0]  rob_entry_num;
    logic        rf_we;
    logic [5:0]  phy_dest;
    logic [31:0] result;
    logic        exception;
    logic        is_store_op;
  } execute_to_commit_bus_t;
endpackage

// File: rtl/exe_commit_arbiter_if.sv
// exe_commit_arbiter_if: execute-unit requests and ROB completion ports
interface exe_commit_arbiter_if import exe_commit_arbiter_pkg::*; #(
  parameter int NUM_UNITS = NUM_EXE_UNITS,
  parameter int NUM_PORTS = NUM_COMMIT_PORTS
);
  logic                   flush;
  logic [NUM_UNITS-1:0]   unit_valid;
  execute_to_commit_bus_t unit_bus [NUM_UNITS];
  logic [NUM_UNITS-1:0]   unit_allowin;
  logic                   rob_ready;
  logic [NUM_PORTS-1:0]   commit_valid;
  execute_to_commit_bus_t commit_bus [NUM_PORTS];
  modport master (output flush, unit_valid, unit_bus, rob_ready,
                  input unit_allowin, commit_valid, commit_bus);
  modport slave (input flush, unit_valid, unit_bus, rob_ready,
                 output unit_allowin, commit_valid, commit_bus);
endinterface

// File: rtl/exe_commit_arbiter_picker.sv
// rr_multi_picker: picks up to K requesters scanning from ptr, one one-hot grant per slot
module rr_multi_picker #(
  parameter int N = 4,
  parameter int K = 2
) (
  input  logic [$clog2(N)-1:0] ptr,
  input  logic [N-1:0]         req,
  output logic [K-1:0][N-1:0]  grant,
  output logic                 any,
  output logic [$clog2(N)-1:0] last
);
  localparam int W = $clog2(N);
  int cnt;
  always_comb begin
    grant = '0;
    last = ptr;
    cnt = 0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (i == (int'(ptr) + j) % N && req[i] && cnt < K) begin
          for (int k = 0; k < K; k++) if (k == cnt) grant[k][i] = 1'b1;
          last = W'(i);
          cnt++;
        end
  end
  assign any = cnt != 0;
endmodule

// File: rtl/exe_commit_arbiter.sv
// exe_commit_arbiter: round-robin grants execute results onto registered ROB completion ports
module exe_commit_arbiter import exe_commit_arbiter_pkg::*; #(
  parameter int NUM_UNITS = NUM_EXE_UNITS,
  parameter int NUM_PORTS = NUM_COMMIT_PORTS
) (
  input logic clk,
  input logic reset,
  exe_commit_arbiter_if.slave io
);
  localparam int W = $clog2(NUM_UNITS);
  logic [W-1:0]                       rr_ptr, last;
  logic [NUM_PORTS-1:0][NUM_UNITS-1:0] grant;
  logic                               any, adv, go;
  logic [NUM_PORTS-1:0]               cv;
  execute_to_commit_bus_t             cb [NUM_PORTS];
  execute_to_commit_bus_t             sel [NUM_PORTS];
  assign adv = !(|cv) || io.rob_ready;
  assign go = adv && !io.flush && !reset;
  rr_multi_picker #(.N(NUM_UNITS), .K(NUM_PORTS)) picker (
    .ptr(rr_ptr), .req(io.unit_valid), .grant(grant), .any(any), .last(last)
  );
  always_comb begin
    io.unit_allowin = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      io.unit_allowin |= go ? grant[p] : '0;
      sel[p] = '0;
      for (int i = 0; i < NUM_UNITS; i++) if (grant[p][i]) sel[p] = io.unit_bus[i];
    end
  end
  // ports without a grant drop valid but keep their last bus value
  always_ff @(posedge clk) begin
    if (reset) begin
      cv <= '0;
      for (int p = 0; p < NUM_PORTS; p++) cb[p] <= '0;
      rr_ptr <= '0;
    end else if (io.flush) begin
      cv <= '0;
    end else if (adv) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cv[p] <= |grant[p];
        if (|grant[p]) cb[p] <= sel[p];
      end
      if (any) rr_ptr <= W'((int'(last) + 1) % NUM_UNITS);
    end
  end
  assign io.commit_valid = cv;
  assign io.commit_bus = cb;
endmodule

// File: tb/tb_exe_commit_arbiter.sv
// tb_exe_commit_arbiter: directed vectors plus a randomised reference-model run
module tb_exe_commit_arbiter;
  import exe_commit_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  exe_commit_arbiter_if #(.NUM_UNITS(4), .NUM_PORTS(2)) io ();
  exe_commit_arbiter #(.NUM_UNITS(4), .NUM_PORTS(2)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic execute_to_commit_bus_t mk(input int tag);
    logic [63:0] r;
    r = {32'(tag) * 32'h9e37_79b9, 32'(tag) ^ 32'h5a5a_a5a5};
    return r[$bits(execute_to_commit_bus_t)-1:0];
  endfunction
  task automatic set_bus(input int base);
    for (int i = 0; i < 4; i++) io.unit_bus[i] = mk(base + i);
  endtask
  logic [3:0]             uv, eg;
  execute_to_commit_bus_t ub [4];
  execute_to_commit_bus_t nb [2];
  execute_to_commit_bus_t m_cb [2];
  execute_to_commit_bus_t tmp;
  logic [1:0]             m_cv;
  logic [63:0]            r;
  int                     m_ptr, cnt, last, wait_cnt [4];
  logic                   go;
  initial begin
    reset = 1'b1;
    io.flush = 1'b0;
    io.rob_ready = 1'b0;
    io.unit_valid = 4'b1111;
    set_bus(10);
    #1 chk("allowin_in_reset", io.unit_allowin, 4'b0000);
    tick;
    tick;
    chk("rst_cv", io.commit_valid, 2'b00);
    chk("rst_cb0", io.commit_bus[0], '0);
    chk("rst_ptr", dut.rr_ptr, 0);
    // all units valid: pairs granted alternately
    reset = 1'b0;
    io.rob_ready = 1'b1;
    #1 chk("t1_allow0", io.unit_allowin, 4'b0011);
    tick;
    chk("t1_ptr0", dut.rr_ptr, 2);
    chk("t1_cv0", io.commit_valid, 2'b11);
    chk("t1_cb0_0", io.commit_bus[0], mk(10));
    chk("t1_cb1_0", io.commit_bus[1], mk(11));
    chk("t1_allow1", io.unit_allowin, 4'b1100);
    tick;
    chk("t1_cb0_1", io.commit_bus[0], mk(12));
    chk("t1_cb1_1", io.commit_bus[1], mk(13));
    chk("t1_ptr1", dut.rr_ptr, 0);
    chk("t1_allow2", io.unit_allowin, 4'b0011);
    // single requester; unused port keeps its old bus
    io.unit_valid = 4'b0100;
    #1 chk("t2_allow0", io.unit_allowin, 4'b0100);
    tick;
    chk("t2_ptr0", dut.rr_ptr, 3);
    chk("t2_cv0", io.commit_valid, 2'b01);
    chk("t2_cb0", io.commit_bus[0], mk(12));
    chk("t2_cb1_held", io.commit_bus[1], mk(13));
    io.unit_bus[2] = mk(40);
    tmp = mk(40);
    #1 chk("t2_allow1", io.unit_allowin, 4'b0100);
    tick;
    chk("t2_cv1", io.commit_valid, 2'b01);
    chk("t2_rob", io.commit_bus[0].rob_entry_num, tmp.rob_entry_num);
    chk("t2_ptr1", dut.rr_ptr, 3);
    // back-pressure from the ROB
    io.unit_valid = 4'b0011;
    set_bus(50);
    #1 chk("t3_allow0", io.unit_allowin, 4'b0011);
    tick;
    chk("t3_cv0", io.commit_valid, 2'b11);
    chk("t3_cb0", io.commit_bus[0], mk(50));
    chk("t3_cb1", io.commit_bus[1], mk(51));
    chk("t3_ptr0", dut.rr_ptr, 2);
    io.rob_ready = 1'b0;
    set_bus(60);
    for (int n = 0; n < 3; n++) begin
      #1 chk("t3_allow_hold", io.unit_allowin, 4'b0000);
      tick;
      chk("t3_cv_hold", io.commit_valid, 2'b11);
      chk("t3_cb0_hold", io.commit_bus[0], mk(50));
      chk("t3_cb1_hold", io.commit_bus[1], mk(51));
    end
    io.rob_ready = 1'b1;
    #1 chk("t3_allow1", io.unit_allowin, 4'b0011);
    tick;
    chk("t3_cv1", io.commit_valid, 2'b11);
    chk("t3_cb0_new", io.commit_bus[0], mk(60));
    chk("t3_cb1_new", io.commit_bus[1], mk(61));
    chk("t3_ptr1", dut.rr_ptr, 2);
    // flush beats rob_ready and new grants
    io.unit_valid = 4'b1111;
    io.flush = 1'b1;
    #1 chk("t4_allow_flush", io.unit_allowin, 4'b0000);
    tick;
    chk("t4_cv", io.commit_valid, 2'b00);
    chk("t4_ptr", dut.rr_ptr, 2);
    io.flush = 1'b0;
    #1 chk("t4_allow_after", io.unit_allowin, 4'b1100);
    tick;
    chk("t4_cv_after", io.commit_valid, 2'b11);
    chk("t4_cb0", io.commit_bus[0], mk(62));
    chk("t4_cb1", io.commit_bus[1], mk(63));
    chk("t4_ptr_after", dut.rr_ptr, 0);
    // reset over flush with a full output stage
    reset = 1'b1;
    io.flush = 1'b1;
    #1 chk("t5_allow", io.unit_allowin, 4'b0000);
    tick;
    chk("t5_cv", io.commit_valid, 2'b00);
    chk("t5_cb0", io.commit_bus[0], '0);
    chk("t5_cb1", io.commit_bus[1], '0);
    chk("t5_ptr", dut.rr_ptr, 0);
    reset = 1'b0;
    io.flush = 1'b0;
    // randomised traffic against a reference model
    m_ptr = 0;
    m_cv = 2'b00;
    for (int i = 0; i < 4; i++) begin
      uv[i] = 1'($urandom_range(0, 1));
      r = {$urandom(), $urandom()};
      ub[i] = r[$bits(execute_to_commit_bus_t)-1:0];
      wait_cnt[i] = 0;
    end
    for (int n = 0; n < 10000; n++) begin
      io.rob_ready = $urandom_range(0, 3) != 0;
      io.unit_valid = uv;
      for (int i = 0; i < 4; i++) io.unit_bus[i] = ub[i];
      go = (m_cv == 2'b00) || io.rob_ready;
      eg = '0;
      cnt = 0;
      last = 0;
      for (int j = 0; j < 4; j++) begin
        int i;
        i = (m_ptr + j) % 4;
        if (go && uv[i] && cnt < 2) begin
          eg[i] = 1'b1;
          nb[cnt] = ub[i];
          cnt++;
          last = i;
        end
      end
      #1 chk("rnd_allowin", io.unit_allowin, eg);
      for (int i = 0; i < 4; i++)
        if (go && uv[i]) begin
          if (eg[i]) begin
            chk("rnd_wait", 64'(wait_cnt[i] <= 1), 1);
            wait_cnt[i] = 0;
          end else wait_cnt[i]++;
        end
      tick;
      if (go) begin
        m_cv = cnt == 2 ? 2'b11 : cnt == 1 ? 2'b01 : 2'b00;
        for (int p = 0; p < cnt; p++) m_cb[p] = nb[p];
        if (cnt > 0) m_ptr = (last + 1) % 4;
      end
      chk("rnd_cv", io.commit_valid, m_cv);
      for (int p = 0; p < 2; p++) if (m_cv[p]) chk("rnd_bus", io.commit_bus[p], m_cb[p]);
      for (int i = 0; i < 4; i++)
        if (eg[i] || !uv[i]) begin
          uv[i] = 1'($urandom_range(0, 1));
          r = {$urandom(), $urandom()};
          ub[i] = r[$bits(execute_to_commit_bus_t)-1:0];
        end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
